instr_decode_queue: RTL and testbench
=====================================

INSTR_DECODE_QUEUE -- requirements
Module: instr_decode_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of buffered instruction entries, range 2..16, power of two.
REQ-002 Parameter PC_W, default 32: width of the PC tag carried with each instruction.
REQ-003 Parameter CHECK_COND, default 1: 1 evaluates the condition field against flags; 0 forces out_cond_pass=1 whenever out_valid=1.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid / in_ready  input / output  1 / 1  fetch-side handshake.
REQ-007 in_instr / in_pc  input / input  32 / PC_W  ARM instruction word and its address.
REQ-008 flush  input  1  synchronous discard of all buffered entries.
REQ-009 flags  input  4  CPSR NZCV, bit 3 = N, bit 0 = V.
REQ-010 out_valid / out_ready  output / input  1 / 1  execute-side handshake.
REQ-011 out_pc  output  PC_W  PC of the head entry.
REQ-012 out_class  output  2  00 data-processing, 01 single data transfer, 10 branch, 11 undefined.
REQ-013 out_cond_pass  output  1  condition evaluation of the head entry.
REQ-014 Data-processing fields: opcode[3:0], set_flags, imm_sel, rn[3:0], rd[3:0], rm[3:0], shift_amt[4:0], shift_type[1:0], rotate[3:0], imm8[7:0].
REQ-015 Transfer fields: offset12[11:0], reg_offset, pre_index, up, byte_sel, write_back, load (rn, rd and rm shared with REQ-014).
REQ-016 Branch fields: link, branch_off[23:0].
REQ-017 count  output  clog2(DEPTH+1)  number of occupied entries.

Function
REQ-018 Storage: circular FIFO of {instr, pc}; push when in_valid&&in_ready; pop when out_valid&&out_ready.
REQ-019 in_ready = (count < DEPTH); in_ready does not depend on out_ready; no push while full.
REQ-020 out_valid = (count > 0); the head entry is held stable while out_valid&&!out_ready.
REQ-021 Latency: an entry pushed at edge N appears at the output (if the FIFO was empty) in the cycle after edge N; no combinational in-to-out bypass.
REQ-022 Simultaneous push and pop: count is unchanged, and both pointers advance modulo DEPTH.
REQ-023 Pointers wrap from DEPTH-1 to 0 with no lost or duplicated entries.
REQ-024 flush=1 sets count and both pointers to 0 at the next edge; a push or pop in the same cycle is ignored.
REQ-025 The decode is combinational from the head entry; every field is 0 when out_valid=0.
REQ-026 Class rules:
  - [27:26]=00 gives class 00.
  - [27:26]=01 gives class 01.
  - [27:25]=101 gives class 10.
  - Anything else gives class 11.
REQ-027 Class 00 field mapping:
  - opcode=[24:21], set_flags=[20], imm_sel=[25], rn=[19:16], rd=[15:12].
  - imm_sel=0: rm=[3:0], shift_amt=[11:7], shift_type=[6:5].
  - imm_sel=1: imm8=[7:0], rotate=[11:8].
REQ-028 Class 01 field mapping:
  - reg_offset=[25], pre_index=[24], up=[23], byte_sel=[22], write_back=[21], load=[20], rn=[19:16], rd=[15:12].
  - reg_offset=1: rm=[3:0], shift_amt=[11:7], shift_type=[6:5].
  - reg_offset=0: offset12=[11:0].
REQ-029 Class 10 field mapping: link=[24], branch_off=[23:0].
REQ-030 Fields not belonging to the decoded class are 0.
REQ-031 Condition table (flags taken in the current cycle):
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z.
  - GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL 1, 1111 gives 0.
REQ-032 Class 11 entries still flow through the FIFO with out_cond_pass=0.

Reset
REQ-033 While reset=0: count=0, pointers=0, out_valid=0, in_ready=1, all decoded outputs 0; storage contents are don't-care.
REQ-034 Assertion of reset mid-operation discards all entries immediately, without waiting for a clock edge.
REQ-035 The first push is accepted at the first rising edge after reset deasserts.

Structure
REQ-036 Shared package arm_decode_pkg holds the following, for reuse by the execute stage:
  - class codes, condition-code constants and the 16 opcode constants;
  - the cond_eval function.
REQ-037 The combinational field decode is a sub-module, instr_field_decode (instruction in, fields and class out); the FIFO and handshake logic stay in instr_decode_queue.

Verification
REQ-038 Push 0xE28DB004, flags 0 -> class 00, opcode 0100, imm_sel 1, rn 13, rd 11, imm8 0x04, rotate 0, cond_pass 1.
REQ-039 Push 0xE59F0014 -> class 01, rn 15, rd 0, offset12 0x014, pre_index 1, up 1, load 1, reg_offset 0; then push 0xEBFFFFFE -> class 10, link 1, branch_off 0xFFFFFE.
REQ-040 Push 0x0A000000 with flags 0000 -> cond_pass 0; set flags 0100 with the entry held -> cond_pass 1 in the same cycle.
REQ-041 Backpressure (DEPTH=4, out_ready=0, push 5 entries back-to-back):
  - in_ready falls after the 4th push and count=4.
  - Release out_ready with a continuous push/pop across pointer wrap for 10 entries -> output order equals input order and count stays constant.
REQ-042 Flush and reset:
  - Assert flush with count=3 plus a concurrent push -> count=0 and out_valid=0 next cycle.
  - Repeat using reset=0 in mid-cycle -> out_valid=0 immediately, with no clock edge.

Source files
------------

// File: rtl/arm_decode_pkg.sv
// rtl/arm_decode_pkg.sv - shared ARM decode constants, field struct and condition evaluation
package arm_decode_pkg;

  typedef enum logic [1:0] {
    CLASS_DP    = 2'b00,
    CLASS_SDT   = 2'b01,
    CLASS_BR    = 2'b10,
    CLASS_UNDEF = 2'b11
  } iclass_e;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  typedef struct packed {
    logic [3:0]  opcode;
    logic        set_flags;
    logic        imm_sel;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [4:0]  shift_amt;
    logic [1:0]  shift_type;
    logic [3:0]  rotate;
    logic [7:0]  imm8;
    logic [11:0] offset12;
    logic        reg_offset;
    logic        pre_index;
    logic        up;
    logic        byte_sel;
    logic        write_back;
    logic        load;
    logic        link;
    logic [23:0] branch_off;
  } fields_t;

  // nzcv ordering matches CPSR[31:28]: bit 3 = N, bit 0 = V
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: return z;
      COND_NE: return !z;
      COND_CS: return c;
      COND_CC: return !c;
      COND_MI: return n;
      COND_PL: return !n;
      COND_VS: return v;
      COND_VC: return !v;
      COND_HI: return c && !z;
      COND_LS: return !c || z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return !z && (n == v);
      COND_LE: return z || (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// rtl/instr_field_decode.sv - combinational ARM class and field decode of one instruction word
module instr_field_decode
  import arm_decode_pkg::*;
(
  input  logic        valid,
  input  logic [31:0] instr,
  output iclass_e     iclass,
  output logic [3:0]  cond,
  output fields_t     f
);

  always_comb begin
    iclass = CLASS_DP;
    cond   = 4'h0;
    f      = '0;
    if (valid) begin
      cond = instr[31:28];
      if (instr[27:26] == 2'b00) begin
        iclass      = CLASS_DP;
        f.opcode    = instr[24:21];
        f.set_flags = instr[20];
        f.imm_sel   = instr[25];
        f.rn        = instr[19:16];
        f.rd        = instr[15:12];
        if (instr[25]) begin
          f.imm8   = instr[7:0];
          f.rotate = instr[11:8];
        end else begin
          f.rm         = instr[3:0];
          f.shift_amt  = instr[11:7];
          f.shift_type = instr[6:5];
        end
      end else if (instr[27:26] == 2'b01) begin
        iclass       = CLASS_SDT;
        f.reg_offset = instr[25];
        f.pre_index  = instr[24];
        f.up         = instr[23];
        f.byte_sel   = instr[22];
        f.write_back = instr[21];
        f.load       = instr[20];
        f.rn         = instr[19:16];
        f.rd         = instr[15:12];
        if (instr[25]) begin
          f.rm         = instr[3:0];
          f.shift_amt  = instr[11:7];
          f.shift_type = instr[6:5];
        end else begin
          f.offset12 = instr[11:0];
        end
      end else if (instr[27:25] == 3'b101) begin
        iclass       = CLASS_BR;
        f.link       = instr[24];
        f.branch_off = instr[23:0];
      end else begin
        iclass = CLASS_UNDEF;
      end
    end
  end

endmodule

// File: rtl/instr_decode_queue.sv
// rtl/instr_decode_queue.sv - instruction FIFO with combinational decode of the head entry
module instr_decode_queue
  import arm_decode_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int PC_W       = 32,
  parameter int CHECK_COND = 1,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  input  logic [3:0]      flags,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [1:0]      out_class,
  output logic            out_cond_pass,
  output logic [3:0]      opcode,
  output logic            set_flags,
  output logic            imm_sel,
  output logic [3:0]      rn,
  output logic [3:0]      rd,
  output logic [3:0]      rm,
  output logic [4:0]      shift_amt,
  output logic [1:0]      shift_type,
  output logic [3:0]      rotate,
  output logic [7:0]      imm8,
  output logic [11:0]     offset12,
  output logic            reg_offset,
  output logic            pre_index,
  output logic            up,
  output logic            byte_sel,
  output logic            write_back,
  output logic            load,
  output logic            link,
  output logic [23:0]     branch_off,
  output logic [CW-1:0]   count
);

  logic [31:0]     mem_instr [DEPTH];
  logic [PC_W-1:0] mem_pc    [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic            push, pop;
  iclass_e         head_class;
  logic [3:0]      head_cond;
  fields_t         head_f;

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: a slot is only visible once count covers it
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_instr[wptr] <= in_instr;
      mem_pc[wptr]    <= in_pc;
    end
  end

  instr_field_decode u_decode (
    .valid  (out_valid),
    .instr  (mem_instr[rptr]),
    .iclass (head_class),
    .cond   (head_cond),
    .f      (head_f)
  );

  assign out_pc    = out_valid ? mem_pc[rptr] : '0;
  assign out_class = head_class;
  assign out_cond_pass = (CHECK_COND != 0)
                       ? (out_valid && (head_class != CLASS_UNDEF) && cond_eval(head_cond, flags))
                       : out_valid;

  assign opcode     = head_f.opcode;
  assign set_flags  = head_f.set_flags;
  assign imm_sel    = head_f.imm_sel;
  assign rn         = head_f.rn;
  assign rd         = head_f.rd;
  assign rm         = head_f.rm;
  assign shift_amt  = head_f.shift_amt;
  assign shift_type = head_f.shift_type;
  assign rotate     = head_f.rotate;
  assign imm8       = head_f.imm8;
  assign offset12   = head_f.offset12;
  assign reg_offset = head_f.reg_offset;
  assign pre_index  = head_f.pre_index;
  assign up         = head_f.up;
  assign byte_sel   = head_f.byte_sel;
  assign write_back = head_f.write_back;
  assign load       = head_f.load;
  assign link       = head_f.link;
  assign branch_off = head_f.branch_off;

endmodule

// File: tb/tb_instr_decode_queue.sv
// tb/tb_instr_decode_queue.sv - directed self-checking bench for instr_decode_queue
module tb_instr_decode_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic        flush;
  logic [3:0]  flags;
  logic        out_valid, out_ready;
  logic [31:0] out_pc;
  logic [1:0]  out_class;
  logic        out_cond_pass;
  logic [3:0]  opcode, rn, rd, rm, rotate;
  logic        set_flags, imm_sel;
  logic [4:0]  shift_amt;
  logic [1:0]  shift_type;
  logic [7:0]  imm8;
  logic [11:0] offset12;
  logic        reg_offset, pre_index, up, byte_sel, write_back, load, link;
  logic [23:0] branch_off;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;
  logic [31:0] mq [$];

  instr_decode_queue #(.DEPTH(4), .PC_W(32), .CHECK_COND(1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .flags(flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_class(out_class), .out_cond_pass(out_cond_pass),
    .opcode(opcode), .set_flags(set_flags), .imm_sel(imm_sel),
    .rn(rn), .rd(rd), .rm(rm), .shift_amt(shift_amt), .shift_type(shift_type),
    .rotate(rotate), .imm8(imm8), .offset12(offset12),
    .reg_offset(reg_offset), .pre_index(pre_index), .up(up), .byte_sel(byte_sel),
    .write_back(write_back), .load(load), .link(link), .branch_off(branch_off),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    #1;
  endtask

  initial begin
    int idx;
    logic exp_push, exp_pop;
    reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; flags = 4'h0; out_ready = 1'b0;

    #2;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_ready", 32'(in_ready), 1);
    check("rst_count", 32'(count), 0);
    check("rst_class", 32'(out_class), 0);
    check("rst_pass",  32'(out_cond_pass), 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // add r11, r13, #4 ; no combinational bypass before the edge
    in_valid = 1'b1; in_instr = 32'hE28DB004; in_pc = 32'h1000;
    #1;
    check("no_bypass", 32'(out_valid), 0);
    @(posedge clk); #1;
    in_valid = 1'b0; #1;
    check("first_push_cnt", 32'(count), 1);
    check("dp_valid", 32'(out_valid), 1);
    check("dp_pc",    out_pc, 32'h1000);
    check("dp_class", 32'(out_class), 0);
    check("dp_opc",   32'(opcode), 4);
    check("dp_imm",   32'(imm_sel), 1);
    check("dp_rn",    32'(rn), 13);
    check("dp_rd",    32'(rd), 11);
    check("dp_imm8",  32'(imm8), 4);
    check("dp_rot",   32'(rotate), 0);
    check("dp_rm",    32'(rm), 0);
    check("dp_pass",  32'(out_cond_pass), 1);
    pop();
    check("dp_popped", 32'(count), 0);

    push(32'hE59F0014, 32'h2000);
    push(32'hEBFFFFFE, 32'h2004);
    check("two_cnt",   32'(count), 2);
    check("ldr_class", 32'(out_class), 1);
    check("ldr_rn",    32'(rn), 15);
    check("ldr_rd",    32'(rd), 0);
    check("ldr_off",   32'(offset12), 32'h014);
    check("ldr_pre",   32'(pre_index), 1);
    check("ldr_up",    32'(up), 1);
    check("ldr_load",  32'(load), 1);
    check("ldr_reg",   32'(reg_offset), 0);
    check("ldr_wb",    32'(write_back), 0);
    check("ldr_opc",   32'(opcode), 0);
    pop();
    check("bl_class", 32'(out_class), 2);
    check("bl_link",  32'(link), 1);
    check("bl_off",   32'(branch_off), 32'hFFFFFE);
    check("bl_pc",    out_pc, 32'h2004);
    check("bl_pass",  32'(out_cond_pass), 1);
    check("bl_rn",    32'(rn), 0);
    pop();

    // beq held at the head while flags change
    push(32'h0A000000, 32'h3000);
    check("beq_z0", 32'(out_cond_pass), 0);
    flags = 4'b0100; #1;
    check("beq_z1", 32'(out_cond_pass), 1);
    pop();

    flags = 4'b1001;
    push(32'hC2800000, 32'h3100);
    check("gt_nv", 32'(out_cond_pass), 1);
    flags = 4'b1101; #1;
    check("gt_z", 32'(out_cond_pass), 0);
    pop();
    flags = 4'h0;
    push(32'hF2800000, 32'h3200);
    check("nv_pass", 32'(out_cond_pass), 0);
    pop();
    push(32'hE8BD8000, 32'h3300);
    check("undef_class", 32'(out_class), 3);
    check("undef_pass",  32'(out_cond_pass), 0);
    check("undef_pc",    out_pc, 32'h3300);
    pop();

    // backpressure: five back-to-back offers into a 4-deep queue
    mq.delete();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_instr = 32'hE1A00000 | i; in_pc = 32'h100 + 4 * i;
      @(posedge clk); #1;
      if (i < 4) mq.push_back(32'h100 + 4 * i);
      if (i == 3) begin
        check("bp_full_cnt",   32'(count), 4);
        check("bp_full_ready", 32'(in_ready), 0);
      end
    end
    check("bp_no_push_full", 32'(count), 4);

    // stream with pop and push every cycle across the pointer wrap
    idx = 4;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (idx < 14);
      in_instr = 32'hE1A00000 | idx;
      in_pc    = 32'h100 + 4 * idx;
      #1;
      check("st_cnt",   32'(count), 32'(mq.size()));
      check("st_ready", 32'(in_ready), 32'(mq.size() < 4));
      if (mq.size() > 0) check("st_order", out_pc, mq[0]);
      exp_push = in_valid && (mq.size() < 4);
      exp_pop  = (mq.size() > 0);
      @(posedge clk); #1;
      if (exp_pop) void'(mq.pop_front());
      if (exp_push) begin
        mq.push_back(32'h100 + 4 * idx);
        idx++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0; #1;
    check("st_drained", 32'(count), 0);
    check("st_all_in",  32'(idx), 14);

    // flush with three entries and a concurrent push
    push(32'hE1A00001, 32'h4000);
    push(32'hE1A00002, 32'h4004);
    push(32'hE1A00003, 32'h4008);
    check("fl_pre_cnt", 32'(count), 3);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'hE1A00004; in_pc = 32'h400C;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; #1;
    check("fl_cnt",   32'(count), 0);
    check("fl_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    check("fl_stays_empty", 32'(out_valid), 0);

    // asynchronous reset in mid-cycle
    push(32'hE1A00005, 32'h5000);
    push(32'hE1A00006, 32'h5004);
    check("ar_pre_cnt", 32'(count), 2);
    reset = 1'b0; #1;
    check("ar_valid", 32'(out_valid), 0);
    check("ar_cnt",   32'(count), 0);
    check("ar_ready", 32'(in_ready), 1);
    check("ar_pc",    out_pc, 0);
    @(negedge clk);
    reset = 1'b1;
    push(32'hE1A00007, 32'h6000);
    check("ar_first_push", 32'(count), 1);
    check("ar_first_pc",   out_pc, 32'h6000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
